// File: rtl/iob_native_initiator_pkg.sv
// Shared types and constants for the IOb native initiator.
package iob_native_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2,
      RSP     = 2'd3
   } state_t;

   // Read data returned when a read times out; sliced to DATA_W.
   localparam logic [1023:0] RD_TO_DATA = '1;

endpackage

// File: rtl/iob_native_initiator_timer.sv
// Timeout counter: clear wins over enable; expired on the limit-th cycle.
module iob_native_initiator_timer #(
   parameter int CNT_W = 11
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = en_i && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/iob_native_initiator.sv
// Single-outstanding IOb native initiator bridge.
// Timeout logic enabled with `define IOB_NATIVE_INITIATOR_TIMEOUT_EN.
module iob_native_initiator
   import iob_native_initiator_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int TO_CYCLES = 1024
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                cke_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [ADDR_W-1:0]   cmd_addr_i,
   input  logic [DATA_W-1:0]   cmd_wdata_i,
   input  logic [DATA_W/8-1:0] cmd_wstrb_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [DATA_W-1:0]   rsp_rdata_o,
   output logic                rsp_err_o,
   output logic                iob_avalid_o,
   output logic [ADDR_W-1:0]   iob_addr_o,
   output logic [DATA_W-1:0]   iob_wdata_o,
   output logic [DATA_W/8-1:0] iob_wstrb_o,
   input  logic                iob_ready_i,
   input  logic [DATA_W-1:0]   iob_rdata_i,
   input  logic                iob_rvalid_i,
   output logic                busy_o,
   output logic                err_o,
   input  logic                err_clr_i
);

   state_t state_q, state_d;
   logic   is_wr;
   logic   lat_en;
   logic   rd_cap;
   logic   to_hit;
   logic   timeout;

   assign is_wr = |iob_wstrb_o;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
      end else if (cke_i) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      lat_en       = 1'b0;
      rd_cap       = 1'b0;
      to_hit       = 1'b0;
      cmd_ready_o  = 1'b0;
      iob_avalid_o = 1'b0;
      rsp_valid_o  = 1'b0;
      busy_o       = 1'b1;
      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (cmd_valid_i) begin
               lat_en  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            iob_avalid_o = 1'b1;
            if (iob_ready_i) begin
               state_d = is_wr ? IDLE : WAIT_RD;
            end else if (timeout) begin
               to_hit  = 1'b1;
               state_d = is_wr ? IDLE : RSP;
            end
         end
         WAIT_RD: begin
            if (iob_rvalid_i) begin
               rd_cap  = 1'b1;
               state_d = RSP;
            end else if (timeout) begin
               to_hit  = 1'b1;
               state_d = RSP;
            end
         end
         RSP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         iob_addr_o  <= '0;
         iob_wdata_o <= '0;
         iob_wstrb_o <= '0;
      end else if (cke_i && lat_en) begin
         iob_addr_o  <= cmd_addr_i;
         iob_wdata_o <= cmd_wdata_i;
         iob_wstrb_o <= cmd_wstrb_i;
      end
   end

   // A timed-out write leaves rdata alone; only a read reports it.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rsp_rdata_o <= '0;
      end else if (cke_i) begin
         if (rd_cap) begin
            rsp_rdata_o <= iob_rdata_i;
         end else if (to_hit && !is_wr) begin
            rsp_rdata_o <= RD_TO_DATA[DATA_W-1:0];
         end
      end
   end

`ifdef IOB_NATIVE_INITIATOR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYCLES + 1);

   logic tmr_en;
   logic tmr_clr;
   logic rsp_err_q;
   logic err_q;

   assign tmr_en  = cke_i && (state_q == REQ || state_q == WAIT_RD);
   assign tmr_clr = cke_i && (state_d != state_q);

   iob_native_initiator_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .en_i     (tmr_en),
      .clr_i    (tmr_clr),
      .limit_i  (CNT_W'(TO_CYCLES)),
      .expired_o(timeout)
   );

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rsp_err_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (cke_i) begin
         if (rd_cap) begin
            rsp_err_q <= 1'b0;
         end else if (to_hit && !is_wr) begin
            rsp_err_q <= 1'b1;
         end
         if (to_hit) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
      end
   end

   assign rsp_err_o = rsp_err_q;
   assign err_o     = err_q;
`else
   localparam int unused_to_cycles = TO_CYCLES;
   logic unused_err_clr;

   assign unused_err_clr = err_clr_i;
   assign timeout        = 1'b0;
   assign rsp_err_o      = 1'b0;
   assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_iob_native_initiator.sv
// Directed self-checking bench for iob_native_initiator.
module tb_iob_native_initiator;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic          cke = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          iob_avalid;
   logic [AW-1:0] iob_addr;
   logic [DW-1:0] iob_wdata;
   logic [3:0]    iob_wstrb;
   logic          iob_ready = 1'b0;
   logic [DW-1:0] iob_rdata = '0;
   logic          iob_rvalid = 1'b0;
   logic          busy;
   logic          err;
   logic          err_clr = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   iob_native_initiator #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .TO_CYCLES(TO)
   ) dut (
      .clk_i       (clk),
      .arst_n_i    (arst_n),
      .cke_i       (cke),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .cmd_wstrb_i (cmd_wstrb),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .iob_avalid_o(iob_avalid),
      .iob_addr_o  (iob_addr),
      .iob_wdata_o (iob_wdata),
      .iob_wstrb_o (iob_wstrb),
      .iob_ready_i (iob_ready),
      .iob_rdata_i (iob_rdata),
      .iob_rvalid_i(iob_rvalid),
      .busy_o      (busy),
      .err_o       (err),
      .err_clr_i   (err_clr)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_wstrb = s;
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int hi;
      int rv;

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_avalid", iob_avalid, 0);
      chk("rst_addr", iob_addr, 0);
      chk("rst_wdata", iob_wdata, 0);
      chk("rst_wstrb", iob_wstrb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      arst_n = 1'b1;
      cyc();

      // write, ready tied high
      iob_ready = 1'b1;
      chk("wr_cmd_ready", cmd_ready, 1);
      send(16'h0004, 32'h0000_00AB, 4'h1);
      chk("wr_avalid_1st", iob_avalid, 1);
      chk("wr_addr", iob_addr, 16'h0004);
      chk("wr_wdata", iob_wdata, 32'hAB);
      chk("wr_wstrb", iob_wstrb, 4'h1);
      hi = 0;
      rv = 0;
      for (int i = 0; i < 5; i++) begin
         hi += int'(iob_avalid);
         rv += int'(rsp_valid);
         cyc();
      end
      chk("wr_avalid_cycles", hi, 1);
      chk("wr_no_rsp", rv, 0);
      chk("wr_addr_hold", iob_addr, 16'h0004);
      chk("wr_idle", busy, 0);

      // read, ready after 3 cycles, rvalid 2 cycles later
      iob_ready = 1'b0;
      rsp_ready = 1'b1;
      send(16'h0008, 32'h0, 4'h0);
      repeat (3) cyc();
      chk("rd_avalid_wait", iob_avalid, 1);
      chk("rd_addr", iob_addr, 16'h0008);
      iob_ready = 1'b1;
      cyc();
      iob_ready = 1'b0;
      chk("rd_avalid_drop", iob_avalid, 0);
      chk("rd_busy", busy, 1);
      cyc();
      chk("rd_no_rsp_yet", rsp_valid, 0);
      iob_rvalid = 1'b1;
      iob_rdata  = 32'h1234_5678;
      cyc();
      iob_rvalid = 1'b0;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rdata", rsp_rdata, 32'h1234_5678);
      chk("rd_rsp_err", rsp_err, 0);
      cyc();
      chk("rd_done", rsp_valid, 0);
      chk("rd_cmd_ready", cmd_ready, 1);

      // read with response backpressure; stray rvalid in RSP
      rsp_ready = 1'b0;
      iob_ready = 1'b1;
      send(16'h0010, 32'h0, 4'h0);
      cyc();
      iob_ready  = 1'b0;
      iob_rvalid = 1'b1;
      iob_rdata  = 32'hCAFE_F00D;
      cyc();
      iob_rdata  = 32'h0BAD_0BAD;
      cmd_valid  = 1'b1;
      cmd_wstrb  = 4'hF;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid_%0d", i), rsp_valid, 1);
         chk($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hCAFE_F00D);
         chk($sformatf("bp_cmd_rdy_%0d", i), cmd_ready, 0);
         cyc();
      end
      iob_rvalid = 1'b0;
      rsp_ready  = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      chk("bp_done_valid", rsp_valid, 0);
      chk("bp_done_idle", busy, 0);

      // stray rvalid while idle
      iob_rvalid = 1'b1;
      iob_rdata  = 32'hDEAD_BEEF;
      repeat (2) cyc();
      iob_rvalid = 1'b0;
      chk("stray_rsp_valid", rsp_valid, 0);
      chk("stray_rdata", rsp_rdata, 32'hCAFE_F00D);
      chk("stray_busy", busy, 0);

      // clock enable holds state
      cke = 1'b0;
      cmd_valid = 1'b1;
      cmd_addr  = 16'h0020;
      cmd_wstrb = 4'hF;
      repeat (2) cyc();
      chk("cke_idle_hold", busy, 0);
      chk("cke_addr_hold", iob_addr, 16'h0010);
      cke = 1'b1;
      send(16'h0020, 32'h5555_AAAA, 4'hF);
      cke = 1'b0;
      iob_ready = 1'b1;
      repeat (2) cyc();
      chk("cke_req_hold", iob_avalid, 1);
      cke = 1'b1;
      cyc();
      iob_ready = 1'b0;
      chk("cke_release", iob_avalid, 0);

`ifdef IOB_NATIVE_INITIATOR_TIMEOUT_EN
      // read timeout, ready never asserted
      rsp_ready = 1'b0;
      send(16'h0030, 32'h0, 4'h0);
      hi = 0;
      for (int i = 0; i < 20 && iob_avalid; i++) begin
         hi++;
         cyc();
      end
      chk("to_avalid_cycles", hi, TO);
      chk("to_avalid_low", iob_avalid, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rdata", rsp_rdata, 32'hFFFF_FFFF);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_err", err, 1);
      rsp_ready = 1'b1;
      repeat (3) cyc();
      chk("to_err_sticky", err, 1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("to_err_clr", err, 0);
      iob_ready = 1'b1;
      send(16'h0040, 32'h0, 4'h0);
      cyc();
      iob_ready = 1'b0;
`else
      // without timeout the initiator waits indefinitely
      rsp_ready = 1'b1;
      send(16'h0030, 32'h0, 4'h0);
      repeat (20) cyc();
      chk("nto_avalid_hold", iob_avalid, 1);
      chk("nto_err", err, 0);
      chk("nto_rsp_err", rsp_err, 0);
      iob_ready = 1'b1;
      cyc();
      iob_ready = 1'b0;
`endif

      // reset while in WAIT_RD
      chk("ar_in_wait", busy, 1);
      chk("ar_wait_avalid", iob_avalid, 0);
      arst_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_cmd_ready", cmd_ready, 1);
      chk("ar_addr", iob_addr, 0);
      chk("ar_wstrb", iob_wstrb, 0);
      chk("ar_rdata", rsp_rdata, 0);
      chk("ar_rsp_valid", rsp_valid, 0);
      chk("ar_err", err, 0);
      @(negedge clk);
      arst_n     = 1'b1;
      iob_rvalid = 1'b1;
      iob_rdata  = 32'h0000_0055;
      repeat (2) cyc();
      iob_rvalid = 1'b0;
      chk("ar_late_rvalid", rsp_valid, 0);
      chk("ar_late_rdata", rsp_rdata, 0);
      chk("ar_late_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/iob_native_initiator.md
IOB_NATIVE_INITIATOR -- requirements
Module: iob_native_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: IOb address width.
REQ-002 SHALL have parameter DATA_W, default 32: IOb data width, multiple of 8.
REQ-003 SHALL have parameter TO_CYCLES, default 1024: timeout limit, used only under the timeout macro.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port arst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cke_i  in  1  clock enable; when 0, state, counters and outputs hold.
REQ-007 SHALL have command ports cmd_valid_i in 1, cmd_ready_o out 1, cmd_addr_i in ADDR_W, cmd_wdata_i in DATA_W, cmd_wstrb_i in DATA_W/8; wstrb zero means read.
REQ-008 SHALL have response ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out DATA_W, rsp_err_o out 1.
REQ-009 SHALL have IOb initiator ports iob_avalid_o out 1, iob_addr_o out ADDR_W, iob_wdata_o out DATA_W, iob_wstrb_o out DATA_W/8, iob_ready_i in 1, iob_rdata_i in DATA_W, iob_rvalid_i in 1.
REQ-010 SHALL have status ports busy_o out 1 (state not IDLE) and err_o out 1 (sticky timeout flag), and input err_clr_i in 1.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT_RD, RSP; one transaction outstanding at a time.
REQ-012 IDLE: cmd_ready_o=1; cmd_valid_i&cmd_ready_o latches addr/wdata/wstrb and moves to REQ next cycle; cmd_ready_o=0 in all other states.
REQ-013 REQ: iob_avalid_o=1 with latched addr/wdata/wstrb, held stable until iob_ready_i=1; acceptance at 1 cycle after command handshake at the earliest.
REQ-014 On acceptance of a write (wstrb nonzero): iob_avalid_o drops next cycle, FSM returns to IDLE; no response is produced.
REQ-015 On acceptance of a read: iob_avalid_o drops next cycle, FSM goes to WAIT_RD.
REQ-016 WAIT_RD: first iob_rvalid_i=1 captures iob_rdata_i into rsp_rdata_o, sets rsp_err_o=0, goes to RSP.
REQ-017 RSP: rsp_valid_o=1 with stable rdata/err until rsp_ready_i=1, then IDLE; next command is accepted no earlier than the following cycle.
REQ-018 iob_rvalid_i in IDLE, REQ or RSP SHALL be ignored, with no state or data change.
REQ-019 iob_addr_o/wdata/wstrb SHALL hold last latched values when avalid=0.
REQ-020 err_clr_i SHALL clear err_o; a timeout in the same cycle SHALL win, leaving err_o=1.

Reset
REQ-021 Reset assertion SHALL force IDLE immediately, even mid-transaction; any in-flight read is abandoned and a late rvalid is ignored per REQ-018.
REQ-022 Reset values SHALL be: cmd_ready_o 1, iob_avalid_o 0, iob_addr/wdata/wstrb 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0, busy_o 0, err_o 0, timeout counter 0.

Configuration
REQ-023 With IOB_NATIVE_INITIATOR_TIMEOUT_EN defined: counter clears on entering REQ/WAIT_RD, increments each enabled cycle there; reaching TO_CYCLES drops avalid, sets err_o; a write returns to IDLE, a read goes to RSP with rsp_rdata_o all ones and rsp_err_o=1.
REQ-024 Without the macro: no counter logic, FSM waits indefinitely, err_o and rsp_err_o tied 0, TO_CYCLES unused.

Structure
REQ-025 State encodings and the rdata-on-timeout constant SHALL live in the shared package iob_native_initiator_pkg.
REQ-026 The timeout counter SHALL be the single sub-module iob_native_initiator_timer (enable, clear, limit, expired).

Verification
REQ-027 Write addr 0x0004, wdata 0x000000AB, wstrb 0x1, ready tied 1 -> avalid high exactly 1 cycle, 1 cycle after cmd handshake, no rsp_valid_o.
REQ-028 Read addr 0x0008, ready after 3 cycles, rvalid with 0x12345678 2 cycles later -> rsp_valid_o, rdata 0x12345678, rsp_err_o 0.
REQ-029 Read with rsp_ready_i low for 5 cycles -> rsp_valid_o and rdata stable for 5 cycles; cmd_ready_o low until handshake.
REQ-030 Stray rvalid with 0xDEADBEEF while IDLE -> no rsp_valid_o, rsp_rdata_o unchanged.
REQ-031 Macro on, TO_CYCLES 8, ready never asserted on read -> avalid drops after 8 cycles, rsp_rdata_o 0xFFFFFFFF, rsp_err_o 1, err_o 1 until err_clr_i.
REQ-032 arst_n_i low while in WAIT_RD -> IDLE, all outputs at REQ-022 values; later rvalid is ignored.
